// File: rtl/fpnew_inorder_retire_ctrl_if.sv
// Issue/retire handshake bundle between the upstream issuer, the operation groups and the
// downstream consumer of fpnew_inorder_retire_ctrl.
interface fpnew_inorder_retire_ctrl_if #(
    parameter int unsigned NumGroups      = 4,
    parameter int unsigned MaxOutstanding = 8
);
    localparam int unsigned GrpIdxWidth = $clog2(NumGroups);
    localparam int unsigned CntWidth    = $clog2(MaxOutstanding + 1);

    // Every channel is valid/ready: a transfer happens on a rising clock edge where both are 1.
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [GrpIdxWidth-1:0] opgrp_i;
    logic                   flush_i;
    logic [NumGroups-1:0]   grp_in_valid_o;
    logic [NumGroups-1:0]   grp_in_ready_i;
    logic [NumGroups-1:0]   grp_out_valid_i;
    logic [NumGroups-1:0]   grp_out_ready_o;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [GrpIdxWidth-1:0] out_sel_o;
    logic [CntWidth-1:0]    outstanding_o;
    logic                   busy_o;

    modport slave (
        input  in_valid_i, opgrp_i, flush_i, grp_in_ready_i, grp_out_valid_i, out_ready_i,
        output in_ready_o, grp_in_valid_o, grp_out_ready_o, out_valid_o, out_sel_o,
               outstanding_o, busy_o
    );

    modport master (
        output in_valid_i, opgrp_i, flush_i, grp_in_ready_i, grp_out_valid_i, out_ready_i,
        input  in_ready_o, grp_in_valid_o, grp_out_ready_o, out_valid_o, out_sel_o,
               outstanding_o, busy_o
    );
endinterface

// File: rtl/fpnew_inorder_retire_ctrl.sv
// In-order issue/retire sequencer: logs the target group of every issued op in an order FIFO
// and only lets the group at the FIFO head hand back its result.
module fpnew_inorder_retire_ctrl #(
    parameter int unsigned NumGroups      = 4,
    parameter int unsigned MaxOutstanding = 8
) (
    input logic                        clk_i,
    input logic                        rst_ni,
    fpnew_inorder_retire_ctrl_if.slave bus
);
    localparam int unsigned GrpIdxWidth = $clog2(NumGroups);
    localparam int unsigned CntWidth    = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrWidth    = $clog2(MaxOutstanding);

    typedef logic [GrpIdxWidth-1:0] grp_idx_t;

    grp_idx_t            fifo_q [MaxOutstanding];
    grp_idx_t            fifo_d [MaxOutstanding];
    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0] count_q, count_d;

    logic     full, empty;
    logic     sel_ok, sel_ready, head_valid;
    logic     push, pop;
    grp_idx_t head;

    // Select decode by loop: an index with no matching group leaves sel_ok low.
    always_comb begin
        full       = (count_q == CntWidth'(MaxOutstanding));
        empty      = (count_q == '0);
        head       = fifo_q[rd_ptr_q];
        sel_ok     = 1'b0;
        sel_ready  = 1'b0;
        head_valid = 1'b0;
        for (int unsigned g = 0; g < NumGroups; g++) begin
            if (bus.opgrp_i == GrpIdxWidth'(g)) begin
                sel_ok    = 1'b1;
                sel_ready = bus.grp_in_ready_i[g];
            end
            if (head == GrpIdxWidth'(g)) begin
                head_valid = bus.grp_out_valid_i[g];
            end
        end
    end

    // Issue is gated by full rather than by full-minus-pop to keep ready free of the retire path.
    always_comb begin
        bus.in_ready_o      = sel_ok & sel_ready & ~full & ~bus.flush_i;
        bus.out_valid_o     = ~empty & head_valid & ~bus.flush_i;
        bus.out_sel_o       = empty ? '0 : head;
        bus.outstanding_o   = count_q;
        bus.busy_o          = ~empty;
        bus.grp_in_valid_o  = '0;
        bus.grp_out_ready_o = '0;
        for (int unsigned g = 0; g < NumGroups; g++) begin
            bus.grp_in_valid_o[g]  = bus.in_valid_i & sel_ok & (bus.opgrp_i == GrpIdxWidth'(g))
                                     & ~full & ~bus.flush_i;
            bus.grp_out_ready_o[g] = ~empty & (head == GrpIdxWidth'(g)) & bus.out_ready_i
                                     & ~bus.flush_i;
        end
    end

    assign push = bus.in_valid_i & bus.in_ready_o;
    assign pop  = bus.out_valid_o & bus.out_ready_i;

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                fifo_d[wr_ptr_q] = bus.opgrp_i;
                wr_ptr_d         = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_q   <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= CntWidth'(MaxOutstanding));
    a_out_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(bus.grp_out_ready_o));
    a_in_valid_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(bus.grp_in_valid_o));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop && empty));

endmodule

// File: tb/tb_fpnew_inorder_retire_ctrl.sv
// Bench for fpnew_inorder_retire_ctrl: latency-modelled groups, an expected-order queue popped
// by a retire monitor, and directed checks for reset, full, flush and bad-select corners.
module tb_fpnew_inorder_retire_ctrl;
    logic clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    fpnew_inorder_retire_ctrl_if #(.NumGroups(4), .MaxOutstanding(8)) bus ();
    fpnew_inorder_retire_ctrl_if #(.NumGroups(3), .MaxOutstanding(8)) bus3 ();

    fpnew_inorder_retire_ctrl #(.NumGroups(4), .MaxOutstanding(8)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    fpnew_inorder_retire_ctrl #(.NumGroups(3), .MaxOutstanding(8)) dut3 (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus3)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- group latency model ----------------
    int         lat [4] = '{1, 2, 4, 3};
    int         tq [4][8];
    int         hd [4];
    int         cnt [4];
    int         cyc;
    logic       model_en;
    logic [3:0] man_valid;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc <= 0;
            for (int g = 0; g < 4; g++) begin
                hd[g]  <= 0;
                cnt[g] <= 0;
            end
        end else begin
            cyc <= cyc + 1;
            for (int g = 0; g < 4; g++) begin
                if (bus.flush_i || !model_en) begin
                    hd[g]  <= 0;
                    cnt[g] <= 0;
                end else begin
                    if (bus.grp_in_valid_o[g] && bus.grp_in_ready_i[g])
                        tq[g][(hd[g] + cnt[g]) % 8] <= cyc + lat[g];
                    if (bus.grp_out_valid_i[g] && bus.grp_out_ready_o[g])
                        hd[g] <= (hd[g] + 1) % 8;
                    cnt[g] <= cnt[g] + int'(bus.grp_in_valid_o[g] && bus.grp_in_ready_i[g])
                                     - int'(bus.grp_out_valid_i[g] && bus.grp_out_ready_o[g]);
                end
            end
        end
    end

    always_comb begin
        bus.grp_out_valid_i = man_valid;
        if (model_en) begin
            for (int g = 0; g < 4; g++)
                bus.grp_out_valid_i[g] = (cnt[g] > 0) && (tq[g][hd[g]] <= cyc);
        end
    end

    // ---------------- scoreboard ----------------
    logic [1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid_o && bus.out_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_retire actual_sel=%0d required=none", bus.out_sel_o);
            end else begin
                check("retire_sel", 32'(bus.out_sel_o), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int g);
        int n;
        n = 0;
        bus.in_valid_i = 1'b1;
        bus.opgrp_i    = 2'(g);
        @(negedge clk);
        while (!bus.in_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready_o) check("issue_timeout", 32'(bus.in_ready_o), 32'd1);
        else exp_q.push_back(2'(g));
        step();
        bus.in_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        while ((exp_q.size() != 0 || bus.outstanding_o != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(bus.outstanding_o), 32'd0);
        check({name, "_queue"}, 32'(exp_q.size()), 32'd0);
        step();
    endtask

    int  pat3  [8]  = '{1, 3, 0, 2, 1, 3, 0, 2};
    int  pat20 [20] = '{0, 3, 2, 1, 1, 0, 2, 3, 2, 2, 0, 1, 3, 3, 1, 0, 2, 0, 3, 1};
    int  pat5  [6]  = '{3, 2, 1, 0, 3, 2};
    bit  seen_hold;

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        checks++;
        failures++;
        $display("FAIL global_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        model_en = 1'b1;
        man_valid = 4'b0000;
        bus.in_valid_i = 1'b0;
        bus.opgrp_i = 2'd0;
        bus.flush_i = 1'b0;
        bus.grp_in_ready_i = 4'b1111;
        bus.out_ready_i = 1'b0;
        bus3.in_valid_i = 1'b0;
        bus3.opgrp_i = 2'd0;
        bus3.flush_i = 1'b0;
        bus3.grp_in_ready_i = 3'b111;
        bus3.grp_out_valid_i = 3'b000;
        bus3.out_ready_i = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // reset state
        @(negedge clk);
        check("rst_outstanding", 32'(bus.outstanding_o), 32'd0);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        check("rst_grp_out_ready", 32'(bus.grp_out_ready_o), 32'd0);
        check("rst_out_sel", 32'(bus.out_sel_o), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
        step();

        // 1: async reset with three ops in flight
        issue(1);
        issue(2);
        issue(3);
        @(negedge clk);
        check("t1_outstanding3", 32'(bus.outstanding_o), 32'd3);
        step();
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("t1_rst_outstanding", 32'(bus.outstanding_o), 32'd0);
        check("t1_rst_busy", 32'(bus.busy_o), 32'd0);
        check("t1_rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // 2: slow G2 issued before fast G0 still retires first
        bus.out_ready_i = 1'b1;
        issue(2);
        issue(0);
        seen_hold = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!seen_hold && bus.grp_out_valid_i[0] && exp_q.size() == 2) begin
                seen_hold = 1'b1;
                check("t2_g0_held_ready", 32'(bus.grp_out_ready_o), 32'b0100);
                check("t2_head_sel", 32'(bus.out_sel_o), 32'd2);
                check("t2_head_not_valid", 32'(bus.out_valid_o), 32'd0);
            end
        end
        check("t2_hold_observed", 32'(seen_hold), 32'd1);
        step();
        wait_drain("t2_drain");

        // 3: fill to capacity with results stalled, then one pop
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) issue(pat3[i]);
        bus.in_valid_i = 1'b1;
        bus.opgrp_i = 2'd0;
        @(negedge clk);
        check("t3_full_outstanding", 32'(bus.outstanding_o), 32'd8);
        check("t3_full_in_ready", 32'(bus.in_ready_o), 32'd0);
        check("t3_full_grp_in_valid", 32'(bus.grp_in_valid_o), 32'd0);
        step();
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        check("t3_pop_valid", 32'(bus.out_valid_o), 32'd1);
        check("t3_pop_cycle_in_ready", 32'(bus.in_ready_o), 32'd0);
        step();
        bus.out_ready_i = 1'b0;
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        check("t3_after_pop_outstanding", 32'(bus.outstanding_o), 32'd7);
        check("t3_after_pop_in_ready", 32'(bus.in_ready_o), 32'd1);
        step();
        wait_drain("t3_drain");

        // 4: simultaneous push and pop at count 5, then 20 ops through pointer wrap
        bus.out_ready_i = 1'b0;
        issue(0);
        issue(1);
        issue(2);
        issue(3);
        issue(0);
        repeat (6) step();
        bus.out_ready_i = 1'b1;
        bus.in_valid_i = 1'b1;
        bus.opgrp_i = 2'd1;
        @(negedge clk);
        check("t4_pop_side", 32'(bus.out_valid_o), 32'd1);
        check("t4_push_side", 32'(bus.in_ready_o), 32'd1);
        exp_q.push_back(2'd1);
        step();
        bus.in_valid_i = 1'b0;
        bus.out_ready_i = 1'b0;
        @(negedge clk);
        check("t4_count_steady", 32'(bus.outstanding_o), 32'd5);
        step();
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) issue(pat20[i]);
        wait_drain("t4_drain");

        // 5: flush with six in flight and an issue pending
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) issue(pat5[i]);
        bus.in_valid_i = 1'b1;
        bus.opgrp_i = 2'd2;
        bus.flush_i = 1'b1;
        @(negedge clk);
        check("t5_flush_grp_in_valid", 32'(bus.grp_in_valid_o), 32'd0);
        check("t5_flush_in_ready", 32'(bus.in_ready_o), 32'd0);
        check("t5_flush_out_valid", 32'(bus.out_valid_o), 32'd0);
        check("t5_flush_grp_out_ready", 32'(bus.grp_out_ready_o), 32'd0);
        @(posedge clk);
        exp_q.delete();
        #1;
        bus.flush_i = 1'b0;
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        check("t5_post_outstanding", 32'(bus.outstanding_o), 32'd0);
        check("t5_post_busy", 32'(bus.busy_o), 32'd0);
        model_en = 1'b0;
        man_valid = 4'b0100;
        bus.out_ready_i = 1'b1;
        #1;
        check("t5_stale_grp_out_ready", 32'(bus.grp_out_ready_o), 32'd0);
        check("t5_stale_out_valid", 32'(bus.out_valid_o), 32'd0);
        step();
        @(negedge clk);
        check("t5_stale_outstanding", 32'(bus.outstanding_o), 32'd0);
        man_valid = 4'b0000;
        model_en = 1'b1;
        bus.out_ready_i = 1'b0;
        step();

        // 6: out-of-range select on a three-group instance
        bus3.in_valid_i = 1'b1;
        bus3.opgrp_i = 2'd1;
        @(negedge clk);
        check("t6_good_in_ready", 32'(bus3.in_ready_o), 32'd1);
        step();
        bus3.opgrp_i = 2'd3;
        @(negedge clk);
        check("t6_bad_in_ready", 32'(bus3.in_ready_o), 32'd0);
        check("t6_bad_grp_in_valid", 32'(bus3.grp_in_valid_o), 32'd0);
        check("t6_count_before", 32'(bus3.outstanding_o), 32'd1);
        step();
        @(negedge clk);
        check("t6_count_unchanged", 32'(bus3.outstanding_o), 32'd1);
        bus3.opgrp_i = 2'd2;
        #1;
        check("t6_top_in_ready", 32'(bus3.in_ready_o), 32'd1);
        check("t6_top_grp_in_valid", 32'(bus3.grp_in_valid_o), 32'b100);
        step();
        bus3.in_valid_i = 1'b0;
        @(negedge clk);
        check("t6_count_after", 32'(bus3.outstanding_o), 32'd2);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
